// File: rtl/dac_wavegen_pkg.sv
// Shared definitions for the DDS waveform source that feeds the 8-bit R2R DAC.
//   - register map addresses for the byte-wide write port
//   - waveform mode encoding
//   - DAC mid-scale code and amplitude reset value
package dac_wavegen_pkg;

  localparam logic [2:0] ADDR_FREQ_LO = 3'd0;
  localparam logic [2:0] ADDR_FREQ_HI = 3'd1;
  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_AMP     = 3'd3;
  localparam logic [2:0] ADDR_DIV     = 3'd4;

  typedef enum logic [1:0] {
    WAVE_SAW = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_DC  = 2'd3
  } wave_mode_e;

  localparam logic [7:0] CODE_MID = 8'h80;
  localparam logic [7:0] AMP_RST  = 8'hFF;

  // Width of the signed (w - 128) * AMP product carried out of stage 1.
  localparam int PROD_W = 18;

endpackage

// File: rtl/dac_wave_shaper.sv
// Stage 1 of the sample pipeline: waveform select and amplitude multiply.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   p_i        top 8 bits of the sample's phase
//   mode_i     waveform mode (wave_mode_e encoding)
//   amp_i      amplitude captured with the sample
//   prod_o     registered signed product (w - 128) * amp
//   dc_o       registered flag: sample is a DC sample (bypasses scaling)
//   dc_code_o  registered DC code (the amplitude itself)
module dac_wave_shaper
  import dac_wavegen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         p_i,
  input  logic [1:0]         mode_i,
  input  logic [7:0]         amp_i,
  output logic [PROD_W-1:0]  prod_o,
  output logic               dc_o,
  output logic [7:0]         dc_code_o
);

  logic [7:0]                w;
  logic signed [8:0]         w_c;
  logic signed [8:0]         amp_s;
  logic signed [PROD_W-1:0]  prod_d;
  logic [PROD_W-1:0]         prod_q;
  logic                      dc_q;
  logic [7:0]                dc_code_q;

  always_comb begin
    w = p_i;
    case (wave_mode_e'(mode_i))
      WAVE_SAW: w = p_i;
      // 2p for the rising half, 2(255-p) = 2*~p for the falling half.
      WAVE_TRI: w = p_i[7] ? {~p_i[6:0], 1'b0} : {p_i[6:0], 1'b0};
      WAVE_SQR: w = {8{p_i[7]}};
      default:  w = p_i;
    endcase
    w_c    = $signed({1'b0, w}) - 9'sd128;
    amp_s  = $signed({1'b0, amp_i});
    prod_d = PROD_W'(w_c) * PROD_W'(amp_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      dc_q      <= 1'b0;
      dc_code_q <= CODE_MID;
    end else begin
      prod_q    <= prod_d;
      dc_q      <= (wave_mode_e'(mode_i) == WAVE_DC);
      dc_code_q <= amp_i;
    end
  end

  assign prod_o    = prod_q;
  assign dc_o      = dc_q;
  assign dc_code_o = dc_code_q;

endmodule

// File: rtl/dac_wavegen.sv
// DDS waveform source driving the parallel code bits of the 8-bit R2R DAC.
// Register file, prescaler, phase accumulator, final offset/clamp register
// and the valid/sync delay line live here; shaping/multiply is in
// dac_wave_shaper.
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   wr_en       register write strobe
//   wr_addr     register address (0 FREQ_LO, 1 FREQ_HI, 2 CTRL, 3 AMP, 4 DIV)
//   wr_data     write data
//   code        DAC code
//   code_valid  one-cycle pulse when code takes a new sample
//   sync        pulse with code_valid for the sample whose phase step wrapped
module dac_wavegen
  import dac_wavegen_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int CODE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  output logic              sync
);

  // Flag delay line: index 0 = phase stage, 1 = shaper stage, 2 = output.
  localparam int NSTG = 3;

  // Register file
  logic [7:0]   freq_shadow_q;
  logic [15:0]  freq_q;
  wave_mode_e   mode_q;
  logic         enable_q;
  logic [7:0]   amp_q;
  logic [7:0]   div_q;

  // Datapath state
  logic [7:0]          cnt_q, cnt_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PHASE_W:0]    phase_sum;
  logic                tick;
  wave_mode_e          mode_s0_q, mode_s0_d;
  logic [7:0]          amp_s0_q, amp_s0_d;
  logic [NSTG-1:0]     vld_q, vld_d;
  logic [NSTG-1:0]     wrap_q, wrap_d;
  logic [7:0]          code_q, code_d;

  logic [PROD_W-1:0]        prod_s1;
  logic signed [PROD_W-1:0] scaled;
  logic signed [PROD_W-1:0] code_sum;
  logic [7:0]               code_calc;
  logic                     dc_s1;
  logic [7:0]               dc_code_s1;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      freq_shadow_q <= '0;
      freq_q        <= '0;
      mode_q        <= WAVE_SAW;
      enable_q      <= 1'b0;
      amp_q         <= AMP_RST;
      div_q         <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_FREQ_LO: freq_shadow_q <= wr_data;
        // Both bytes land together so the accumulator never sees a torn step.
        ADDR_FREQ_HI: freq_q <= {wr_data, freq_shadow_q};
        ADDR_CTRL: begin
          mode_q   <= wave_mode_e'(wr_data[1:0]);
          enable_q <= wr_data[2];
        end
        ADDR_AMP:     amp_q <= wr_data;
        ADDR_DIV:     div_q <= wr_data;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------- prescaler / accumulator
  always_comb begin
    // >= rather than == so lowering DIV below the running count still ticks.
    tick      = enable_q && (cnt_q >= div_q);
    phase_sum = {1'b0, phase_q} + (PHASE_W + 1)'(freq_q);
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    mode_s0_d = mode_s0_q;
    amp_s0_d  = amp_s0_q;
    if (!enable_q) begin
      cnt_d   = '0;
      phase_d = '0;
    end else if (tick) begin
      cnt_d     = '0;
      phase_d   = phase_sum[PHASE_W-1:0];
      // Mode and amplitude travel with the sample so a mid-run write only
      // affects samples ticked after it.
      mode_s0_d = mode_q;
      amp_s0_d  = amp_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // ----------------------------------------------------- valid / sync delay
  assign vld_d[0]  = tick;
  assign wrap_d[0] = tick & phase_sum[PHASE_W];

  generate
    for (genvar gi = 1; gi < NSTG; gi++) begin : g_flag_dly
      // Disable flushes in-flight samples.
      assign vld_d[gi]  = enable_q & vld_q[gi-1];
      assign wrap_d[gi] = enable_q & wrap_q[gi-1];
    end
  endgenerate

  // ---------------------------------------------------------------- stage 1
  dac_wave_shaper u_shaper (
    .clk       (clk),
    .rst       (rst),
    .p_i       (phase_q[PHASE_W-1 -: 8]),
    .mode_i    (mode_s0_q),
    .amp_i     (amp_s0_q),
    .prod_o    (prod_s1),
    .dc_o      (dc_s1),
    .dc_code_o (dc_code_s1)
  );

  // ---------------------------------------------------------- output stage
  always_comb begin
    scaled   = $signed(prod_s1) >>> 8;
    code_sum = scaled + PROD_W'(signed'(9'sd128));
    // Range is provably 0..254; the clamp just keeps any surprise bounded.
    if (code_sum < 0)
      code_calc = 8'h00;
    else if (code_sum > PROD_W'(signed'(10'sd255)))
      code_calc = 8'hFF;
    else
      code_calc = code_sum[7:0];

    code_d = code_q;
    if (!enable_q)
      code_d = CODE_MID;
    else if (vld_q[1])
      code_d = dc_s1 ? dc_code_s1 : code_calc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      phase_q   <= '0;
      mode_s0_q <= WAVE_SAW;
      amp_s0_q  <= AMP_RST;
      vld_q     <= '0;
      wrap_q    <= '0;
      code_q    <= CODE_MID;
    end else begin
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      mode_s0_q <= mode_s0_d;
      amp_s0_q  <= amp_s0_d;
      vld_q     <= vld_d;
      wrap_q    <= wrap_d;
      code_q    <= code_d;
    end
  end

  assign code       = CODE_W'(code_q);
  assign code_valid = vld_q[NSTG-1];
  assign sync       = wrap_q[NSTG-1];

endmodule

// File: tb/tb_dac_wavegen.sv
// Directed self-checking bench for dac_wavegen.
module tb_dac_wavegen;
  import dac_wavegen_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] code;
  logic       code_valid;
  logic       sync;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dac_wavegen #(.PHASE_W(16), .CODE_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .code       (code),
    .code_valid (code_valid),
    .sync       (sync)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    step();
    wr_en   = 1'b0;
    $display("wr addr=%0d data=0x%02h", a, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_code"},  code,       32'h80);
    check_eq({tag, "_valid"}, code_valid, 32'h0);
    check_eq({tag, "_sync"},  sync,       32'h0);
  endtask

  // Saw at AMP=0xFF, worked out by hand: 0->0, 1..128->p, 129..255->p-1.
  function automatic int saw_ff(input int p);
    if (p == 0)        return 0;
    else if (p <= 128) return p;
    else               return p - 1;
  endfunction

  int sq_code [8] = '{64, 191, 191, 64, 64, 191, 191, 64};
  int sq_sync [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int tri_hi  [2] = '{8'h40, 8'hC8};
  int tri_exp [2] = '{128, 110};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int syncs;
    int ph, f_cur, shadow, sum;
    int p_hist [0:40];
    int w_hist [0:40];

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // ---- idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("idle");
    end

    // ---- saw, freq 0x0100, DIV 0, AMP left at reset value
    do_reset();
    reg_wr(ADDR_FREQ_LO, 8'h00);
    reg_wr(ADDR_FREQ_HI, 8'h01);
    reg_wr(ADDR_DIV, 8'h00);
    reg_wr(ADDR_CTRL, 8'h04);
    syncs = 0;
    for (int n = 1; n <= 302; n++) begin
      step();
      if (n <= 2) begin
        check_eq("saw_lat_valid", code_valid, 32'h0);
      end else begin
        int k;
        k = n - 2;
        check_eq("saw_valid", code_valid, 32'h1);
        check_eq("saw_code", code, 32'(saw_ff(k % 256)));
        check_eq("saw_sync", sync, (k % 256 == 0) ? 32'h1 : 32'h0);
        if (sync) syncs++;
      end
    end
    check_eq("saw_sync_count", 32'(syncs), 32'd1);

    // ---- square, AMP 0x80, freq 0x4000, DIV 3
    do_reset();
    reg_wr(ADDR_FREQ_LO, 8'h00);
    reg_wr(ADDR_FREQ_HI, 8'h40);
    reg_wr(ADDR_AMP, 8'h80);
    reg_wr(ADDR_DIV, 8'h03);
    reg_wr(ADDR_CTRL, 8'h06);
    for (int n = 1; n <= 36; n++) begin
      step();
      if (n >= 6 && (n - 6) % 4 == 0 && (n - 6) / 4 < 8) begin
        int j;
        j = (n - 6) / 4;
        check_eq("sqr_valid", code_valid, 32'h1);
        check_eq("sqr_code", code, 32'(sq_code[j]));
        check_eq("sqr_sync", sync, 32'(sq_sync[j]));
      end else begin
        check_eq("sqr_gap_valid", code_valid, 32'h0);
        check_eq("sqr_gap_sync", sync, 32'h0);
      end
    end

    // ---- triangle with p held: preload one step, then freq 0
    for (int t = 0; t < 2; t++) begin
      do_reset();
      reg_wr(ADDR_FREQ_LO, 8'h00);
      reg_wr(ADDR_FREQ_HI, 8'(tri_hi[t]));
      reg_wr(ADDR_CTRL, 8'h05);
      reg_wr(ADDR_FREQ_HI, 8'h00);
      step();
      check_eq("tri_lat_valid", code_valid, 32'h0);
      for (int i = 0; i < 3; i++) begin
        step();
        check_eq("tri_valid", code_valid, 32'h1);
        check_eq("tri_code", code, 32'(tri_exp[t]));
      end
    end

    // ---- FREQ_LO alone, addr 6, then FREQ_HI commit mid-run
    do_reset();
    reg_wr(ADDR_FREQ_LO, 8'h00);
    reg_wr(ADDR_FREQ_HI, 8'h01);
    reg_wr(ADDR_CTRL, 8'h04);
    ph = 0; f_cur = 16'h0100; shadow = 0;
    for (int n = 1; n <= 40; n++) begin
      wr_en = 1'b0;
      if (n == 10) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h80; end
      if (n == 15) begin wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hFF; end
      if (n == 20) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h02; end
      if (wr_en) $display("wr addr=%0d data=0x%02h", wr_addr, wr_data);
      step();
      wr_en = 1'b0;
      sum = ph + f_cur;
      w_hist[n] = (sum >> 16) & 1;
      ph = sum & 16'hFFFF;
      p_hist[n] = ph >> 8;
      if (n == 10) shadow = 8'h80;
      if (n == 20) f_cur = (8'h02 << 8) | shadow;
      if (n >= 3) begin
        check_eq("frq_valid", code_valid, 32'h1);
        check_eq("frq_code", code, 32'(saw_ff(p_hist[n-2])));
        check_eq("frq_sync", sync, 32'(w_hist[n-2]));
      end else begin
        check_eq("frq_lat_valid", code_valid, 32'h0);
      end
    end

    // ---- DC, disable, mid-run reset
    do_reset();
    reg_wr(ADDR_AMP, 8'h40);
    reg_wr(ADDR_CTRL, 8'h07);
    step();
    check_idle("dc_lat1");
    step();
    check_idle("dc_lat2");
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("dc_valid", code_valid, 32'h1);
      check_eq("dc_code", code, 32'h40);
    end
    reg_wr(ADDR_CTRL, 8'h03);
    step();
    check_idle("dc_off");
    step();
    check_idle("dc_off2");
    reg_wr(ADDR_CTRL, 8'h07);
    repeat (4) step();
    check_eq("dc_re_valid", code_valid, 32'h1);
    check_eq("dc_re_code", code, 32'h40);
    rst = 1'b1;
    step();
    check_idle("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst_after");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
